// File: rtl/sp_usb_fifo_if.sv
// sp_usb_fifo_if: FT245 control strobes plus kernel-side TX/RX stream signals.
// Kernel/host logic connects through master; the bridge connects through slave.
interface sp_usb_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;
    logic             rxf_n;
    logic             txe_n;
    logic             rd_n;
    logic             wr_n;
    logic             oe_n;
    logic [WIDTH-1:0] din;
    logic             write;
    logic             full;
    logic [WIDTH-1:0] dout;
    logic             read;
    logic             avail;
    logic [LW-1:0]    tx_level;
    logic [LW-1:0]    rx_level;
    modport slave (
        input  rxf_n, txe_n, din, write, read,
        output rd_n, wr_n, oe_n, full, dout, avail, tx_level, rx_level
    );
    modport master (
        output rxf_n, txe_n, din, write, read,
        input  rd_n, wr_n, oe_n, full, dout, avail, tx_level, rx_level
    );
endinterface

// File: rtl/sp_usb_fifo.sv
// sp_usb_fifo: FT245 sync USB FIFO bridge with TX/RX word FIFOs, little-endian
// byte (de)serialisation and alternating-priority half-duplex bus arbitration.
module sp_usb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    inout  wire  [7:0]   usb_data,
    sp_usb_fifo_if.slave bus
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int AW = LW - 1;
    localparam int NB = WIDTH / 8;
    localparam int BW = NB > 1 ? $clog2(NB) : 1;
    localparam logic [3:0] S_IDLE  = 4'b0001;
    localparam logic [3:0] S_WRITE = 4'b0010;
    localparam logic [3:0] S_OE    = 4'b0100;
    localparam logic [3:0] S_READ  = 4'b1000;

    logic [3:0]       r_state, w_next;
    logic [WIDTH-1:0] r_tx_mem [DEPTH];
    logic [WIDTH-1:0] r_rx_mem [DEPTH];
    logic [LW-1:0]    r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [BW-1:0]    r_tb, r_rb;
    logic [WIDTH-1:0] r_asm;
    logic             r_pri_rx;
    logic [LW-1:0]    w_tx_lvl, w_rx_lvl;
    logic [BW+2:0]    w_tb_sh, w_rb_sh;
    logic [WIDTH-1:0] w_tx_head, w_rx_word;
    logic             w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
    logic             w_tx_el, w_rx_el, w_tx_last, w_rx_last;

    assign w_tx_lvl  = r_tx_wp - r_tx_rp;
    assign w_rx_lvl  = r_rx_wp - r_rx_rp;
    assign w_tx_last = r_tb == BW'(NB - 1);
    assign w_rx_last = r_rb == BW'(NB - 1);
    assign w_tx_push = bus.write && w_tx_lvl != LW'(DEPTH);
    assign w_tx_pop  = r_state[1] && w_tx_last;
    assign w_rx_push = r_state[3] && w_rx_last;
    assign w_rx_pop  = bus.read && w_rx_lvl != '0;
    assign w_tx_el   = w_tx_lvl != '0 && !bus.txe_n;
    assign w_rx_el   = !bus.rxf_n && w_rx_lvl != LW'(DEPTH);
    assign w_tb_sh   = {r_tb, 3'b000};
    assign w_rb_sh   = {r_rb, 3'b000};
    assign w_tx_head = r_tx_mem[r_tx_rp[AW-1:0]];

    // The bus is only ever driven while WRITE holds oe_n high.
    assign usb_data = r_state[1] ? w_tx_head[w_tb_sh +: 8] : 8'bz;

    assign bus.full     = w_tx_lvl == LW'(DEPTH);
    assign bus.avail    = w_rx_lvl != '0;
    assign bus.dout     = r_rx_mem[r_rx_rp[AW-1:0]];
    assign bus.tx_level = w_tx_lvl;
    assign bus.rx_level = w_rx_lvl;

    always_comb begin
        w_rx_word = r_asm;
        w_rx_word[w_rb_sh +: 8] = usb_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = (r_state == S_IDLE)
               ? ((w_tx_el && (!w_rx_el || !r_pri_rx)) ? S_WRITE : w_rx_el ? S_OE : S_IDLE)
               : (r_state == S_OE && !bus.rxf_n) ? S_READ : S_IDLE;
    end

    always_comb begin
        bus.wr_n = !r_state[1];
        bus.oe_n = !(r_state[2] || r_state[3]);
        bus.rd_n = !r_state[3];
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= bus.din;
        if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= w_rx_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_tb     <= '0;
            r_rb     <= '0;
            r_asm    <= '0;
            r_pri_rx <= 1'b0;
        end else begin
            r_tx_wp <= r_tx_wp + LW'(w_tx_push);
            r_tx_rp <= r_tx_rp + LW'(w_tx_pop);
            r_rx_wp <= r_rx_wp + LW'(w_rx_push);
            r_rx_rp <= r_rx_rp + LW'(w_rx_pop);
            if (r_state[1]) begin
                r_tb     <= w_tx_last ? '0 : r_tb + 1'b1;
                r_pri_rx <= 1'b1;
            end
            if (r_state[3]) begin
                r_rb     <= w_rx_last ? '0 : r_rb + 1'b1;
                r_asm    <= w_rx_word;
                r_pri_rx <= 1'b0;
            end
        end
    end
endmodule
